scoreboard_regfile: RTL and testbench
=====================================

SCOREBOARD_REGFILE -- requirements
Module: scoreboard_regfile

Interface
REQ-001 Parameter WIDTH, default 64: data bits per register.
REQ-002 Parameter DEPTH, default 32: number of registers; power of two, >= 2; AW = log2(DEPTH).
REQ-003 Parameter NREAD, default 2: number of independent read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 31: hard-wired zero register index (LEGv8 XZR).
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 rd_addr  in  NREAD*AW  read addresses, port i in bits [i*AW +: AW].
REQ-008 rd_data  out  NREAD*WIDTH  read data, port i in bits [i*WIDTH +: WIDTH].
REQ-009 rd_busy  out  NREAD  1 = register addressed by port i has a pending write.
REQ-010 wr_en  in  1  writeback strobe.
REQ-011 wr_addr  in  AW  writeback register index.
REQ-012 wr_data  in  WIDTH  writeback data.
REQ-013 iss_en  in  1  issue strobe; marks iss_addr pending.
REQ-014 iss_addr  in  AW  destination register of issued instruction.
REQ-015 busy_count  out  log2(DEPTH)+1  number of registers currently pending.

Function
REQ-016 Reads SHALL be combinational: rd_data[i] = reg[rd_addr[i]], rd_busy[i] = busy[rd_addr[i]].
REQ-017 Writes SHALL occur on the rising clock edge when wr_en=1; reg[wr_addr] <= wr_data.
REQ-018 A write SHALL clear busy[wr_addr] on the same edge.
REQ-019 iss_en=1 SHALL set busy[iss_addr] on the rising edge.
REQ-020 iss_en and wr_en on the same edge with iss_addr == wr_addr: data written AND busy left set (new producer wins).
REQ-021 iss_en to an already-busy register: busy stays set, busy_count unchanged.
REQ-022 wr_en to a non-busy register: data written, busy stays clear, no error.
REQ-023 ZERO_REG: rd_data reads 0, rd_busy reads 0, writes and issues ignored, never counted.
REQ-024 busy_count SHALL equal the population count of busy[] after each edge; +1, -1 or 0 per cycle; max DEPTH-1.
REQ-025 Multiple read ports addressing the same register SHALL return identical data and busy.
REQ-026 Out-of-range addresses cannot occur (DEPTH power of two).

Reset
REQ-027 reset=1 at a rising edge SHALL clear all registers to 0, all busy bits, and busy_count to 0.
REQ-028 reset SHALL take priority over wr_en and iss_en in the same cycle.
REQ-029 Outputs after reset: rd_data all 0, rd_busy all 0, busy_count 0.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when wr_en=1 and rd_addr[i]==wr_addr (not ZERO_REG), rd_data[i] = wr_data and rd_busy[i] = 0 combinationally in the same cycle.
REQ-031 REGFILE_BYPASS_EN undefined: no forwarding; read returns stored value and stored busy until the edge.
REQ-032 Bypass SHALL NOT alter state update behaviour; a same-cycle issue to wr_addr still leaves busy set after the edge.

Structure
REQ-033 Shared package regfile_pkg: default WIDTH/DEPTH/NREAD/ZERO_REG constants and the AW derivation function.
REQ-034 Sub-module rf_read_port (one instance per read port): address decode, zero-register masking, optional bypass mux.
REQ-035 Storage array, busy vector and busy counter reside in the top module.

Verification
REQ-036 Reset, then write 0x1111 to each reg 0..30 on successive cycles -> each reads back 0x1111 on both ports; reg 31 reads 0.
REQ-037 Issue r5, next cycle write r5=0xDEAD -> rd_busy high one cycle, busy_count 1 then 0, rd_data 0xDEAD.
REQ-038 Same cycle issue r7 and write r7=0xBEEF -> after edge rd_data 0xBEEF, rd_busy 1, busy_count 1.
REQ-039 Issue r31 and write r31=0xFFFF -> rd_data 0, rd_busy 0, busy_count 0.
REQ-040 With REGFILE_BYPASS_EN: wr_en r3=0x1234 while port 0 reads r3 -> rd_data 0x1234 before edge; without macro -> old value.
REQ-041 Issue r1..r4, assert reset while writing r2 -> all busy clear, busy_count 0, r2 reads 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address-width helper for the scoreboard register file
//
// Purpose: default geometry constants for scoreboard_regfile and rf_read_port,
//          plus aw_of(), which derives the address width from the register count.
// Ports:   none (package).
package regfile_pkg;

   localparam int DEF_WIDTH    = 64;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NREAD    = 2;
   localparam int DEF_ZERO_REG = 31;

   // Address width for a power-of-two register count (DEPTH >= 2).
   function automatic int aw_of(input int depth);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < depth) begin
            w = i + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port of the scoreboard register file
//
// Purpose: selects one register and its busy bit by address, forces the
//          hard-wired zero register to read as 0 / not busy, and (when
//          REGFILE_BYPASS_EN is defined) forwards an in-flight writeback
//          so the reader sees the new value and a cleared busy bit.
// Ports:
//   rd_addr   in   register index for this port
//   regs_flat in   all register contents, register i in [i*WIDTH +: WIDTH]
//   busy      in   pending-write vector, one bit per register
//   wr_en     in   writeback strobe (used only for forwarding)
//   wr_addr   in   writeback register index (used only for forwarding)
//   wr_data   in   writeback data (used only for forwarding)
//   rd_data   out  read data
//   rd_busy   out  1 = addressed register has a pending write
// Configuration macro: REGFILE_BYPASS_EN
module rf_read_port
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int AW       = aw_of(DEPTH)
) (
   input  logic [AW-1:0]          rd_addr,
   input  logic [DEPTH*WIDTH-1:0] regs_flat,
   input  logic [DEPTH-1:0]       busy,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   rd_busy
);

   logic             is_zero;
   logic [WIDTH-1:0] stored_data;
   logic             stored_busy;

`ifdef REGFILE_BYPASS_EN
   logic             fwd_hit;

   always_comb begin
      is_zero     = (rd_addr == AW'(ZERO_REG));
      stored_data = regs_flat[int'(rd_addr)*WIDTH +: WIDTH];
      stored_busy = busy[rd_addr];
      // The zero register never forwards: its writes are discarded.
      fwd_hit     = wr_en && (wr_addr == rd_addr) && !is_zero;
      rd_data     = stored_data;
      rd_busy     = stored_busy;
      if (is_zero) begin
         rd_data = '0;
         rd_busy = 1'b0;
      end else if (fwd_hit) begin
         rd_data = wr_data;
         rd_busy = 1'b0;
      end
   end
`else
   logic unused_wr;
   assign unused_wr = ^{wr_en, wr_addr, wr_data};

   always_comb begin
      is_zero     = (rd_addr == AW'(ZERO_REG));
      stored_data = regs_flat[int'(rd_addr)*WIDTH +: WIDTH];
      stored_busy = busy[rd_addr];
      rd_data     = is_zero ? '0 : stored_data;
      rd_busy     = is_zero ? 1'b0 : stored_busy;
   end
`endif

endmodule

// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - register file with per-register pending-write scoreboard
//
// Purpose: DEPTH x WIDTH register file with NREAD combinational read ports,
//          one writeback port and one issue port. Issue marks a destination
//          busy; writeback stores data and clears busy. busy_count tracks the
//          number of pending registers. Register ZERO_REG is hard-wired to 0.
// Ports:
//   clock       in   single clock, rising edge
//   reset       in   synchronous, active-high
//   rd_addr     in   NREAD*AW read addresses, port i in [i*AW +: AW]
//   rd_data     out  NREAD*WIDTH read data, port i in [i*WIDTH +: WIDTH]
//   rd_busy     out  NREAD busy flags, one per read port
//   wr_en       in   writeback strobe
//   wr_addr     in   writeback register index
//   wr_data     in   writeback data
//   iss_en      in   issue strobe
//   iss_addr    in   issued destination register index
//   busy_count  out  number of registers currently pending
// Configuration macro: REGFILE_BYPASS_EN (same-cycle writeback forwarding in read ports)
module scoreboard_regfile
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NREAD    = DEF_NREAD,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int AW       = aw_of(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [NREAD-1:0]       rd_busy,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   iss_en,
   input  logic [AW-1:0]          iss_addr,
   output logic [AW:0]            busy_count
);

   logic [WIDTH-1:0]       regs_q [DEPTH];
   logic [WIDTH-1:0]       regs_d [DEPTH];
   logic [DEPTH-1:0]       busy_q;
   logic [DEPTH-1:0]       busy_d;
   logic [AW:0]            busy_count_q;
   logic [AW:0]            busy_count_d;
   logic [DEPTH*WIDTH-1:0] regs_flat;

   logic wr_ok;
   logic iss_set;
   logic wr_clr;
   logic cnt_inc;
   logic cnt_dec;

   always_comb begin
      regs_d       = regs_q;
      busy_d       = busy_q;
      busy_count_d = busy_count_q;

      wr_ok   = wr_en && (wr_addr != AW'(ZERO_REG));
      iss_set = iss_en && (iss_addr != AW'(ZERO_REG));
      // A same-register issue is a newer producer, so its busy bit survives
      // the writeback of the older one.
      wr_clr  = wr_ok && !(iss_set && (iss_addr == wr_addr));

      cnt_inc = iss_set && !busy_q[iss_addr];
      cnt_dec = wr_clr && busy_q[wr_addr];

      if (wr_ok) begin
         regs_d[wr_addr] = wr_data;
      end
      if (wr_clr) begin
         busy_d[wr_addr] = 1'b0;
      end
      if (iss_set) begin
         busy_d[iss_addr] = 1'b1;
      end

      unique case ({cnt_inc, cnt_dec})
         2'b10:   busy_count_d = busy_count_q + 1'b1;
         2'b01:   busy_count_d = busy_count_q - 1'b1;
         default: busy_count_d = busy_count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         regs_flat[i*WIDTH +: WIDTH] = regs_q[i];
      end
   end

   assign busy_count = busy_count_q;

   for (genvar p = 0; p < NREAD; p++) begin : g_rd
      rf_read_port #(
         .WIDTH    (WIDTH),
         .DEPTH    (DEPTH),
         .ZERO_REG (ZERO_REG),
         .AW       (AW)
      ) u_port (
         .rd_addr   (rd_addr[p*AW +: AW]),
         .regs_flat (regs_flat),
         .busy      (busy_q),
         .wr_en     (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .rd_data   (rd_data[p*WIDTH +: WIDTH]),
         .rd_busy   (rd_busy[p])
      );
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - scoreboard bench for scoreboard_regfile
module tb_scoreboard_regfile;

   localparam int W  = 64;
   localparam int AW = 5;
   localparam int NR = 2;

   logic              clock;
   logic              reset;
   logic [NR*AW-1:0]  rd_addr;
   logic [NR*W-1:0]   rd_data;
   logic [NR-1:0]     rd_busy;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [W-1:0]      wr_data;
   logic              iss_en;
   logic [AW-1:0]     iss_addr;
   logic [AW:0]       busy_count;

   scoreboard_regfile dut (
      .clock      (clock),
      .reset      (reset),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_busy    (rd_busy),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .iss_en     (iss_en),
      .iss_addr   (iss_addr),
      .busy_count (busy_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      int          port;
      logic [63:0] data;
      logic        busy;
      int          count;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Monitor: every falling edge, compare all expectations queued this cycle.
   always @(negedge clock) begin
      while (exp_q.size() > 0) begin
         exp_t        e;
         logic [63:0] got_d;
         logic        got_b;
         int          got_c;
         e     = exp_q.pop_front();
         got_d = rd_data[e.port*W +: W];
         got_b = rd_busy[e.port];
         got_c = int'(busy_count);
         total++;
         if (got_d !== e.data || got_b !== e.busy || got_c != e.count) begin
            bad++;
            $display("FAIL %s port%0d: got data=%h busy=%b count=%0d, want data=%h busy=%b count=%0d",
                     e.name, e.port, got_d, got_b, got_c, e.data, e.busy, e.count);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic we, input int wa, input logic [63:0] wd,
                        input logic ie, input int ia);
      wr_en    = we;
      wr_addr  = AW'(wa);
      wr_data  = wd;
      iss_en   = ie;
      iss_addr = AW'(ia);
   endtask

   task automatic idle();
      drive(1'b0, 0, 64'h0, 1'b0, 0);
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic expect_rd(input string n, input int p, input logic [63:0] d,
                            input logic b, input int c);
      exp_t e;
      e.name  = n;
      e.port  = p;
      e.data  = d;
      e.busy  = b;
      e.count = c;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset   = 1'b1;
      rd_addr = '0;
      idle();
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      set_rd(0, 0);
      set_rd(1, 5);
      expect_rd("reset_p0", 0, 64'h0, 1'b0, 0);
      expect_rd("reset_p1", 1, 64'h0, 1'b0, 0);
      tick();

      // Fill 0..30 with 0x1111; r31 write is ignored
      for (int r = 0; r < 31; r++) begin
         drive(1'b1, r, 64'h1111, 1'b0, 0);
         tick();
      end
      idle();
      for (int r = 0; r < 32; r++) begin
         set_rd(0, r);
         set_rd(1, r);
         expect_rd("fill_p0", 0, (r == 31) ? 64'h0 : 64'h1111, 1'b0, 0);
         expect_rd("fill_p1", 1, (r == 31) ? 64'h0 : 64'h1111, 1'b0, 0);
         tick();
      end

      // Distinct per-register values to expose address decode faults
      for (int r = 0; r < 32; r++) begin
         drive(1'b1, r, 64'h1000 + 64'(r), 1'b0, 0);
         tick();
      end
      idle();
      for (int r = 0; r < 32; r++) begin
         set_rd(0, r);
         set_rd(1, 31 - r);
         expect_rd("uniq_p0", 0, (r == 31) ? 64'h0 : 64'h1000 + 64'(r), 1'b0, 0);
         expect_rd("uniq_p1", 1, (r == 0) ? 64'h0 : 64'h1000 + 64'(31 - r), 1'b0, 0);
         tick();
      end

      // Issue r5, then write r5
      drive(1'b0, 0, 64'h0, 1'b1, 5);
      set_rd(0, 5);
      set_rd(1, 5);
      expect_rd("iss5_pre", 0, 64'h1005, 1'b0, 0);
      tick();
      drive(1'b1, 5, 64'hDEAD, 1'b0, 0);
      expect_rd("iss5_busy_p0", 0, BYP ? 64'hDEAD : 64'h1005, BYP ? 1'b0 : 1'b1, 1);
      expect_rd("iss5_busy_p1", 1, BYP ? 64'hDEAD : 64'h1005, BYP ? 1'b0 : 1'b1, 1);
      tick();
      idle();
      expect_rd("wr5_done", 0, 64'hDEAD, 1'b0, 0);
      tick();

      // Same-cycle issue and write of r7: new producer keeps busy
      drive(1'b1, 7, 64'hBEEF, 1'b1, 7);
      set_rd(1, 7);
      expect_rd("same7_pre", 1, BYP ? 64'hBEEF : 64'h1007, 1'b0, 0);
      tick();
      idle();
      expect_rd("same7_post", 1, 64'hBEEF, 1'b1, 1);
      tick();
      drive(1'b1, 7, 64'h7777, 1'b0, 0);
      expect_rd("wr7_pre", 1, BYP ? 64'h7777 : 64'hBEEF, BYP ? 1'b0 : 1'b1, 1);
      tick();
      idle();
      expect_rd("wr7_post", 1, 64'h7777, 1'b0, 0);
      tick();

      // Zero register ignores issue and write, never forwards
      drive(1'b1, 31, 64'hFFFF, 1'b1, 31);
      set_rd(0, 31);
      set_rd(1, 31);
      expect_rd("zero_pre", 0, 64'h0, 1'b0, 0);
      tick();
      idle();
      expect_rd("zero_post_p0", 0, 64'h0, 1'b0, 0);
      expect_rd("zero_post_p1", 1, 64'h0, 1'b0, 0);
      tick();

      // Forwarding (or not) of a same-cycle write to r3
      drive(1'b1, 3, 64'h1234, 1'b0, 0);
      set_rd(0, 3);
      set_rd(1, 4);
      expect_rd("byp3_p0", 0, BYP ? 64'h1234 : 64'h1003, 1'b0, 0);
      expect_rd("byp3_p1", 1, 64'h1004, 1'b0, 0);
      tick();
      idle();
      expect_rd("wr3_post", 0, 64'h1234, 1'b0, 0);
      tick();

      // Re-issue of a busy register; write to a non-busy register
      drive(1'b0, 0, 64'h0, 1'b1, 2);
      tick();
      drive(1'b0, 0, 64'h0, 1'b1, 2);
      set_rd(0, 2);
      expect_rd("reiss2_pre", 0, 64'h1002, 1'b1, 1);
      tick();
      idle();
      expect_rd("reiss2_post", 0, 64'h1002, 1'b1, 1);
      tick();
      drive(1'b1, 9, 64'h9999, 1'b0, 0);
      tick();
      idle();
      set_rd(1, 9);
      expect_rd("wr_nonbusy9", 1, 64'h9999, 1'b0, 1);
      tick();
      drive(1'b1, 2, 64'h2222, 1'b0, 0);
      tick();
      idle();
      expect_rd("clr2", 0, 64'h2222, 1'b0, 0);
      tick();

      // Issue r1..r4, then a simultaneous issue/clear on different registers
      for (int r = 1; r <= 4; r++) begin
         drive(1'b0, 0, 64'h0, 1'b1, r);
         tick();
      end
      idle();
      set_rd(0, 4);
      expect_rd("four_busy", 0, 64'h1004, 1'b1, 4);
      tick();
      drive(1'b1, 1, 64'hAAAA, 1'b1, 6);
      tick();
      idle();
      set_rd(0, 1);
      set_rd(1, 6);
      expect_rd("swap_p0", 0, 64'hAAAA, 1'b0, 4);
      expect_rd("swap_p1", 1, 64'h1006, 1'b1, 4);
      tick();

      // Reset wins over a same-cycle write and issue
      drive(1'b1, 2, 64'h5555, 1'b1, 8);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      idle();
      set_rd(0, 2);
      set_rd(1, 6);
      expect_rd("rst2_p0", 0, 64'h0, 1'b0, 0);
      expect_rd("rst2_p1", 1, 64'h0, 1'b0, 0);
      tick();
      tick();

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
